// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, space selects and widths.
// Imported by mem_responder and mem_lat_counter.
package mem_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic SPACE_INSTR = 1'b0;
    localparam logic SPACE_DATA  = 1'b1;

    localparam int INSTR_W = 32;
    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int LAT_W   = 3;
endpackage

// File: rtl/mem_lat_counter.sv
// Latency down-counter: load wins over decrement, decrement stops at zero.
// o_zero is a registered-state flag, valid the cycle after load.
module mem_lat_counter
    import mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [LAT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);
    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding instruction/data memory responder with fixed LATENCY from accept to rsp_valid.
// Response is held stable until rsp_ready; no new request is accepted outside IDLE.
module mem_responder
    import mem_pkg::*;
#(
    parameter int IMEM_DEPTH = 16,
    parameter int DMEM_DEPTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_space,
    input  logic               req_we,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [INSTR_W-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [INSTR_W-1:0] rsp_rdata,
    output logic               rsp_err
);
    localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [LAT_W-1:0] LAT_VAL = LAT_W'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic                w_load;
    logic                w_dec;
    logic                w_zero;
    logic                w_access;
    logic                w_hs;
    logic                w_in_range;
    logic [INSTR_W-1:0]  w_rdata;

    logic                r_space;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INSTR_W-1:0]  r_wdata;
    logic [INSTR_W-1:0]  r_rsp_rdata;
    logic                r_rsp_err;
    logic [15:0]         r_txn_count;

    logic [INSTR_W-1:0]  r_imem [IMEM_DEPTH];
    logic [DATA_W-1:0]   r_dmem [DMEM_DEPTH];

    mem_lat_counter u_lat (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_load_val (LAT_VAL),
        .i_dec      (w_dec),
        .o_zero     (w_zero)
    );

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_access = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_load = 1'b1;
                    w_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_zero) begin
                    w_access = 1'b1;
                    w_next   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_dec     = (r_state == ST_BUSY) && !w_zero;
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign w_hs      = rsp_valid && rsp_ready;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    assign w_in_range = (r_space == SPACE_DATA) ? ({24'd0, r_addr} < 32'(DMEM_DEPTH))
                                                : ({24'd0, r_addr} < 32'(IMEM_DEPTH));

    // Out-of-range and write responses both return zero data.
    always_comb begin
        w_rdata = '0;
        if (w_in_range && !r_we) begin
            if (r_space == SPACE_DATA) begin
                w_rdata = {{(INSTR_W-DATA_W){1'b0}}, r_dmem[r_addr[DA_W-1:0]]};
            end else begin
                w_rdata = r_imem[r_addr[IA_W-1:0]];
            end
        end
    end

    // Memories hold their contents across reset; only the write path initialises them.
    always_ff @(posedge clk) begin
        if (w_access && r_we && w_in_range) begin
            if (r_space == SPACE_DATA) begin
                r_dmem[r_addr[DA_W-1:0]] <= r_wdata[DATA_W-1:0];
            end else begin
                r_imem[r_addr[IA_W-1:0]] <= r_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_space     <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_txn_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_space <= req_space;
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
            if (w_access) begin
                r_rsp_rdata <= w_rdata;
                r_rsp_err   <= !w_in_range;
            end
            if (w_hs && (r_txn_count != 16'hFFFF)) begin
                r_txn_count <= r_txn_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances at LATENCY 2, 3 and 1 exercised with
// a directed vector table plus hand-written backpressure, mid-write reset and back-to-back sequences.
module tb_mem_responder;
    localparam int NDUT = 3;

    logic        clk;
    logic        rst_n     [NDUT];
    logic        req_valid [NDUT];
    logic        req_ready [NDUT];
    logic        req_space [NDUT];
    logic        req_we    [NDUT];
    logic [7:0]  req_addr  [NDUT];
    logic [31:0] req_wdata [NDUT];
    logic        rsp_valid [NDUT];
    logic        rsp_ready [NDUT];
    logic [31:0] rsp_rdata [NDUT];
    logic        rsp_err   [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_responder #(.IMEM_DEPTH(16), .DMEM_DEPTH(16), .LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_space(req_space[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

    mem_responder #(.IMEM_DEPTH(16), .DMEM_DEPTH(16), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_space(req_space[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

    mem_responder #(.IMEM_DEPTH(16), .DMEM_DEPTH(16), .LATENCY(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_space(req_space[2]), .req_we(req_we[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

    typedef struct {
        logic        space;
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one step after an edge with the DUT idle; returns data, error and
    // the number of edges from the acceptance edge until rsp_valid is seen.
    task automatic do_txn(input int k, input logic sp, input logic we, input logic [7:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat);
        req_space[k] = sp;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        req_valid[k] = 1'b1;
        step();
        req_valid[k] = 1'b0;
        lat = 0;
        while (!rsp_valid[k] && lat < 20) begin
            step();
            lat++;
        end
        rd = rsp_rdata[k];
        er = rsp_err[k];
        rsp_ready[k] = 1'b1;
        step();
        rsp_ready[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs [16];
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [15:0] txn_before;
        int          acc_cyc [4];
        int          rsp_cyc [4];
        int          n_acc;
        int          n_rsp;
        logic        w_acc;
        logic        w_hs;
        logic [31:0] b2b_exp [4];

        vecs[0]  = '{1'b0, 1'b1, 8'd3,   32'h2402000A, 32'h00000000, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'd3,   32'h0,        32'h2402000A, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 8'd10,  32'hFFFFFF08, 32'h00000000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 8'd10,  32'h0,        32'h00000008, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 8'd16,  32'h0,        32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'd8,   32'h00000011, 32'h00000000, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 8'd200, 32'hFFFFFF77, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 8'd200, 32'h0,        32'h00000000, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 8'd8,   32'h0,        32'h00000011, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 8'd10,  32'h0,        32'h00000008, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 8'd15,  32'hDEADBEEF, 32'h00000000, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'd15,  32'h0,        32'hDEADBEEF, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 8'd15,  32'h1234563C, 32'h00000000, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 8'd15,  32'h0,        32'h0000003C, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 8'd16,  32'h0,        32'h00000000, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 8'd255, 32'hCAFEF00D, 32'h00000000, 1'b1};

        for (int k = 0; k < NDUT; k++) begin
            rst_n[k] = 1'b0; req_valid[k] = 1'b0; req_space[k] = 1'b0; req_we[k] = 1'b0;
            req_addr[k] = '0; req_wdata[k] = '0; rsp_ready[k] = 1'b0;
        end
        repeat (3) step();
        for (int k = 0; k < NDUT; k++) rst_n[k] = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("reset_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
            chk($sformatf("reset_rsp_valid[%0d]", k), 32'(rsp_valid[k]), 32'd0);
            chk($sformatf("reset_rsp_rdata[%0d]", k), rsp_rdata[k], 32'd0);
            chk($sformatf("reset_rsp_err[%0d]", k), 32'(rsp_err[k]), 32'd0);
        end
        chk("reset_txn0", 32'(u_dut0.r_txn_count), 32'd0);
        step();

        // Directed table on the LATENCY=2 instance.
        for (int i = 0; i < 16; i++) begin
            do_txn(0, vecs[i].space, vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end
        chk("txn_after_table", 32'(u_dut0.r_txn_count), 32'd16);

        // Backpressure: response held five cycles while extra requests are offered.
        req_space[0] = 1'b0; req_we[0] = 1'b0; req_addr[0] = 8'd3; req_valid[0] = 1'b1;
        step();
        req_valid[0] = 1'b0;
        lat = 0;
        while (!rsp_valid[0] && lat < 20) begin step(); lat++; end
        chk("bp_latency", 32'(lat), 32'd2);
        txn_before = u_dut0.r_txn_count;
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = 1'b1;
            req_we[0]    = 1'b1;
            req_addr[0]  = 8'(i);
            chk($sformatf("bp_valid_c%0d", i), 32'(rsp_valid[0]), 32'd1);
            chk($sformatf("bp_rdata_c%0d", i), rsp_rdata[0], 32'h2402000A);
            chk($sformatf("bp_req_ready_c%0d", i), 32'(req_ready[0]), 32'd0);
            step();
        end
        req_valid[0] = 1'b0;
        req_we[0]    = 1'b0;
        rsp_ready[0] = 1'b1;
        chk("bp_txn_held", 32'(u_dut0.r_txn_count), 32'(txn_before));
        step();
        rsp_ready[0] = 1'b0;
        chk("bp_req_ready_after", 32'(req_ready[0]), 32'd1);
        chk("bp_rsp_valid_after", 32'(rsp_valid[0]), 32'd0);
        chk("bp_txn_once", 32'(u_dut0.r_txn_count), 32'(txn_before) + 32'd1);
        repeat (3) step();
        chk("bp_not_queued", 32'(rsp_valid[0]), 32'd0);
        do_txn(0, 1'b0, 1'b0, 8'd0, 32'h0, rd, er, lat);
        chk("bp_no_stray_write_err", 32'(er), 32'd0);
        do_txn(0, 1'b0, 1'b0, 8'd3, 32'h0, rd, er, lat);
        chk("bp_instr3_intact", rd, 32'h2402000A);

        // Reset one cycle after accepting a write on the LATENCY=3 instance.
        do_txn(1, 1'b1, 1'b1, 8'd2, 32'h0000005A, rd, er, lat);
        chk("rst_preload_latency", 32'(lat), 32'd3);
        req_space[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 8'd2;
        req_wdata[1] = 32'h000000C3; req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        step();
        rst_n[1] = 1'b0;
        #1;
        chk("rst_rsp_valid_now", 32'(rsp_valid[1]), 32'd0);
        repeat (4) step();
        chk("rst_rsp_valid_held", 32'(rsp_valid[1]), 32'd0);
        rst_n[1] = 1'b1;
        chk("rst_req_ready_first", 32'(req_ready[1]), 32'd1);
        chk("rst_txn_cleared", 32'(u_dut1.r_txn_count), 32'd0);
        step();
        do_txn(1, 1'b1, 1'b0, 8'd2, 32'h0, rd, er, lat);
        chk("rst_write_abandoned", rd, 32'h0000005A);
        chk("rst_read_err", 32'(er), 32'd0);

        // Back-to-back reads on the LATENCY=1 instance after preloading and a fresh reset.
        b2b_exp[0] = 32'h11110000; b2b_exp[1] = 32'h22220001;
        b2b_exp[2] = 32'h33330002; b2b_exp[3] = 32'h44440003;
        for (int i = 0; i < 4; i++) begin
            do_txn(2, 1'b0, 1'b1, 8'(i), b2b_exp[i], rd, er, lat);
            chk($sformatf("b2b_preload%0d_latency", i), 32'(lat), 32'd1);
        end
        rst_n[2] = 1'b0;
        step();
        rst_n[2] = 1'b1;
        step();
        n_acc = 0; n_rsp = 0;
        req_space[2] = 1'b0; req_we[2] = 1'b0; req_addr[2] = 8'd0;
        req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
        for (int cyc = 0; cyc < 40 && n_rsp < 4; cyc++) begin
            w_acc = req_valid[2] && req_ready[2];
            w_hs  = rsp_valid[2] && rsp_ready[2];
            if (w_hs) begin
                chk($sformatf("b2b_rdata%0d", n_rsp), rsp_rdata[2], b2b_exp[n_rsp]);
                rsp_cyc[n_rsp] = cyc;
                n_rsp++;
            end
            if (w_acc && n_acc < 4) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            step();
            if (w_acc) begin
                if (n_acc < 4) req_addr[2] = 8'(n_acc);
                else req_valid[2] = 1'b0;
            end
        end
        req_valid[2] = 1'b0;
        rsp_ready[2] = 1'b0;
        chk("b2b_responses", 32'(n_rsp), 32'd4);
        // Cycle indices: acceptance edge ends cycle c, rsp_valid after the next edge is seen in c+2.
        for (int i = 0; i < n_rsp && i < n_acc; i++)
            chk($sformatf("b2b_latency%0d", i), 32'(rsp_cyc[i] - acc_cyc[i]), 32'd2);
        for (int i = 1; i < n_acc; i++)
            chk($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);
        step();
        chk("b2b_txn_count", 32'(u_dut2.r_txn_count), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
